// File: rtl/pdm_cic_array.sv
// PDM microphone-array front end: drives the PDM bit clock, captures both stereo
// phases per data line, CIC-decimates every channel and hands out signed PCM frames.
module pdm_cic_array #(
   parameter int NUM_LINES  = 1,
   parameter int OUT_WIDTH  = 12,
   parameter int ORDER      = 3,
   parameter int LOG2_DECIM = 6,
   parameter int CLK_DIV    = 1
) (
   input  logic                             i_clk,
   input  logic                             i_reset_n,
   input  logic [NUM_LINES-1:0]             i_pdm,
   input  logic                             i_enable,
   input  logic                             i_ready,
   output logic                             o_pdmClk,
   output logic [2*NUM_LINES*OUT_WIDTH-1:0] o_data,
   output logic                             o_valid,
   output logic                             o_overrun
);
   localparam int CH = 2*NUM_LINES;
   localparam int G  = ORDER*LOG2_DECIM + 2;
   localparam int SH = G - 1 - OUT_WIDTH;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SW = $clog2(ORDER + 1);
   localparam logic [DW-1:0]        DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [SW-1:0]        SETTLED  = SW'(ORDER);
   localparam logic signed [G-1:0] SAT_MAX  = G'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [G-1:0] SAT_MIN  = ~SAT_MAX;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                  state;
   logic [DW-1:0]           div_cnt;
   logic [LOG2_DECIM-1:0]   dec_cnt;
   logic [SW-1:0]           settle_cnt;
   logic [G-1:0]            integ     [CH][ORDER];
   logic [G-1:0]            integ_nxt [CH][ORDER];
   logic [G-1:0]            latch_q   [CH];
   logic [G-1:0]            comb_dly  [CH][ORDER];
   logic [G-1:0]            comb_in   [CH][ORDER];
   logic [G-1:0]            comb_res  [CH];
   logic signed [G-1:0]     comb_q    [CH];
   logic [CH*OUT_WIDTH-1:0] frame;
   logic                    tick, cap_even, cap_odd, frame_close;
   logic                    latch_stb, latch_show, comb_stb;

   always_comb begin
      tick        = (state == ST_RUN) && (div_cnt == DIV_LAST);
      cap_even    = tick && o_pdmClk;
      cap_odd     = tick && !o_pdmClk;
      frame_close = cap_odd && (dec_cnt == '1);
   end

   // Integrator cascade uses each stage's freshly updated value, so the whole
   // chain advances in one capture edge with no inter-stage latency.
   always_comb begin
      logic [G-1:0] acc;
      logic         cap;
      acc = '0;
      cap = 1'b0;
      for (int unsigned c = 0; c < CH; c++) begin
         cap = (c[0] == 1'b0) ? cap_even : cap_odd;
         acc = i_pdm[c/2] ? G'(1) : '1;
         for (int unsigned s = 0; s < ORDER; s++) begin
            integ_nxt[c][s] = cap ? integ[c][s] + acc : integ[c][s];
            acc = integ_nxt[c][s];
         end
      end
   end

   always_comb begin
      logic [G-1:0] d;
      d = '0;
      for (int unsigned c = 0; c < CH; c++) begin
         d = latch_q[c];
         for (int unsigned s = 0; s < ORDER; s++) begin
            comb_in[c][s] = d;
            d = d - comb_dly[c][s];
         end
         comb_res[c] = d;
      end
   end

   always_comb begin
      logic signed [G-1:0] y;
      y     = '0;
      frame = '0;
      for (int unsigned c = 0; c < CH; c++) begin
         y = comb_q[c] >>> SH;
         if (y > SAT_MAX)
            y = SAT_MAX;
         else if (y < SAT_MIN)
            y = SAT_MIN;
         frame[c*OUT_WIDTH +: OUT_WIDTH] = y[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= ST_IDLE;
         o_pdmClk   <= 1'b0;
         div_cnt    <= '0;
         dec_cnt    <= '0;
         settle_cnt <= '0;
         latch_stb  <= 1'b0;
         latch_show <= 1'b0;
         comb_stb   <= 1'b0;
         for (int unsigned c = 0; c < CH; c++) begin
            latch_q[c] <= '0;
            comb_q[c]  <= '0;
            for (int unsigned s = 0; s < ORDER; s++) begin
               integ[c][s]    <= '0;
               comb_dly[c][s] <= '0;
            end
         end
      end else if (!i_enable) begin
         state      <= ST_IDLE;
         o_pdmClk   <= 1'b0;
         div_cnt    <= '0;
         dec_cnt    <= '0;
         settle_cnt <= '0;
         latch_stb  <= 1'b0;
         latch_show <= 1'b0;
         comb_stb   <= 1'b0;
         for (int unsigned c = 0; c < CH; c++) begin
            latch_q[c] <= '0;
            comb_q[c]  <= '0;
            for (int unsigned s = 0; s < ORDER; s++) begin
               integ[c][s]    <= '0;
               comb_dly[c][s] <= '0;
            end
         end
      end else begin
         if (state == ST_IDLE) begin
            state    <= ST_RUN;
            o_pdmClk <= 1'b1;
            div_cnt  <= '0;
         end else if (tick) begin
            o_pdmClk <= ~o_pdmClk;
            div_cnt  <= '0;
         end else begin
            div_cnt  <= div_cnt + 1'b1;
         end
         if (cap_odd)
            dec_cnt <= dec_cnt + 1'b1;
         for (int unsigned c = 0; c < CH; c++)
            for (int unsigned s = 0; s < ORDER; s++)
               integ[c][s] <= integ_nxt[c][s];

         latch_stb  <= frame_close;
         latch_show <= frame_close && (settle_cnt == SETTLED);
         if (frame_close) begin
            for (int unsigned c = 0; c < CH; c++)
               latch_q[c] <= integ_nxt[c][ORDER-1];
            if (settle_cnt != SETTLED)
               settle_cnt <= settle_cnt + 1'b1;
         end

         comb_stb <= latch_stb && latch_show;
         if (latch_stb) begin
            for (int unsigned c = 0; c < CH; c++) begin
               comb_q[c] <= comb_res[c];
               for (int unsigned s = 0; s < ORDER; s++)
                  comb_dly[c][s] <= comb_in[c][s];
            end
         end
      end
   end

   // A new frame always wins over a same-edge consume; overrun is sticky.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else if (comb_stb) begin
         o_data  <= frame;
         o_valid <= 1'b1;
         if (o_valid && !i_ready)
            o_overrun <= 1'b1;
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pdm_cic_array.sv
// Scoreboard bench for pdm_cic_array: the driver feeds PDM bits and predicts frames
// with a moving-sum CIC model; the monitor pops expectations as frames load.
`timescale 1ns/1ps
module tb_pdm_cic_array;
   localparam int NUM_LINES  = 2;
   localparam int OUT_WIDTH  = 12;
   localparam int ORDER      = 3;
   localparam int LOG2_DECIM = 5;
   localparam int CLK_DIV    = 2;
   localparam int CH         = 2*NUM_LINES;
   localparam int D          = 1 << LOG2_DECIM;
   localparam int G          = ORDER*LOG2_DECIM + 2;
   localparam int SH         = G - 1 - OUT_WIDTH;
   localparam int FRAME_CYC  = 2*D*CLK_DIV;

   logic                    clk = 1'b0, rst_n = 1'b0, en = 1'b0, rdy = 1'b0;
   logic [NUM_LINES-1:0]    pdm = '0;
   logic                    pdm_clk, valid, overrun;
   logic [CH*OUT_WIDTH-1:0] data;

   pdm_cic_array #(
      .NUM_LINES(NUM_LINES), .OUT_WIDTH(OUT_WIDTH), .ORDER(ORDER),
      .LOG2_DECIM(LOG2_DECIM), .CLK_DIV(CLK_DIV)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_pdm(pdm), .i_enable(en), .i_ready(rdy),
      .o_pdmClk(pdm_clk), .o_data(data), .o_valid(valid), .o_overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint                  cyc;
      logic [CH*OUT_WIDTH-1:0] data;
   } exp_t;

   exp_t                    sb[$];
   int                      smp [CH][$];
   int                      checks = 0, failures = 0, frames_seen = 0;
   int                      mode = 1, dens = 50;
   bit                      rdy_rand = 1'b0;
   longint                  cyc = 0, run_e0 = -1, e0_first = -1, first_valid = -1;
   logic [CH*OUT_WIDTH-1:0] data_m = '0;
   logic                    valid_m = 1'b0, ovr_m = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic gen_bit(input int c, input longint p);
      case (mode)
         0:       return $urandom_range(0, 99) < dens;
         1:       return 1'b1;
         2:       return 1'b0;
         3:       return (c/2 == 0);
         4:       return (c%2 == 0);
         default: return (p%2 == 0);
      endcase
   endfunction

   // CIC reference: ORDER cascaded length-D moving sums over the channel's
   // samples since enable (zero history), evaluated at the latest sample.
   function automatic int cic_ref(input int c);
      int cur[$], nxt[$];
      int acc;
      cur = smp[c];
      for (int o = 0; o < ORDER; o++) begin
         nxt = {};
         acc = 0;
         for (int n = 0; n < cur.size(); n++) begin
            acc += cur[n];
            if (n >= D) acc -= cur[n-D];
            nxt.push_back(acc);
         end
         cur = nxt;
      end
      return cur[cur.size()-1];
   endfunction

   task automatic push_frame(input longint at);
      exp_t e;
      int   y;
      e.cyc  = at;
      e.data = '0;
      for (int c = 0; c < CH; c++) begin
         y = cic_ref(c) >>> SH;
         if (y > (1 << (OUT_WIDTH-1)) - 1) y = (1 << (OUT_WIDTH-1)) - 1;
         if (y < -(1 << (OUT_WIDTH-1)))    y = -(1 << (OUT_WIDTH-1));
         e.data[c*OUT_WIDTH +: OUT_WIDTH] = y[OUT_WIDTH-1:0];
      end
      sb.push_back(e);
   endtask

   task automatic clear_samples();
      for (int c = 0; c < CH; c++) smp[c].delete();
   endtask

   // Called at a falling edge; the next rising edge is cycle cyc+1.
   task automatic drive_now();
      longint n, k, q, p;
      if (rdy_rand) rdy = 1'($urandom_range(0, 1));
      n = cyc + 1;
      if (run_e0 < 0 || n <= run_e0) return;
      k = n - run_e0;
      if (k % CLK_DIV != 0) return;
      q = k / CLK_DIV;
      p = (q % 2 == 1) ? (q - 1) / 2 : q / 2 - 1;
      for (int l = 0; l < NUM_LINES; l++) begin
         logic b;
         int   c;
         c = 2*l + ((q % 2 == 1) ? 0 : 1);
         b = gen_bit(c, p);
         pdm[l] = b;
         smp[c].push_back(b ? 1 : -1);
      end
      if (q % 2 == 0 && (p + 1) % D == 0 && (p + 1) / D - 1 >= ORDER)
         push_frame(n + 2);
   endtask

   task automatic run(input int ncyc);
      repeat (ncyc) begin
         @(negedge clk);
         drive_now();
      end
   endtask

   task automatic enable_on();
      @(negedge clk);
      en     = 1'b1;
      run_e0 = cyc + 1;
      if (e0_first < 0) e0_first = run_e0;
      clear_samples();
      drive_now();
   endtask

   task automatic enable_off();
      @(negedge clk);
      en     = 1'b0;
      run_e0 = -1;
      while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc + 1) void'(sb.pop_back());
      clear_samples();
      drive_now();
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      sb = {};
      valid_m = 1'b0;
      ovr_m   = 1'b0;
      data_m  = '0;
      run_e0  = -1;
      clear_samples();
      #1;
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_overrun", overrun, 0);
      check("rst_pdmclk", pdm_clk, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      if (en) run_e0 = cyc + 1;
      drive_now();
   endtask

   // Monitor: applies the handshake rules to the popped expectations.
   initial begin
      exp_t e;
      logic pclk_m;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL frame_stale: expected load at cycle %0d, now %0d", sb[0].cyc, cyc);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (valid_m && !rdy) ovr_m = 1'b1;
            valid_m = 1'b1;
            data_m  = e.data;
            frames_seen++;
         end else if (valid_m && rdy) begin
            valid_m = 1'b0;
         end
         pclk_m = (run_e0 >= 0 && cyc >= run_e0) ? (((cyc - run_e0) / CLK_DIV) % 2 == 0) : 1'b0;
         if (first_valid < 0 && valid) first_valid = cyc;
         check("valid", valid, valid_m);
         check("overrun", overrun, ovr_m);
         check("data", data, data_m);
         check("pdm_clk", pdm_clk, pclk_m);
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int waited;
      rdy = 1'b1;
      mode = 1;
      repeat (3) @(negedge clk);
      check("init_valid", valid, 0);
      check("init_data", data, 0);
      check("init_overrun", overrun, 0);
      check("init_pdmclk", pdm_clk, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(3);

      // All-ones input, consumer always ready
      enable_on();
      run(FRAME_CYC*(ORDER+3) + 4);
      check("first_valid_latency", 64'(first_valid - e0_first), 64'(FRAME_CYC*(ORDER+1) + 2));

      // Pattern changes mid-run: all zeros, line split, phase split, alternating
      for (int m = 2; m <= 5; m++) begin
         mode = m;
         run(FRAME_CYC*3);
      end

      // Random data with random back-pressure
      mode = 0;
      dens = 70;
      rdy_rand = 1'b1;
      run(FRAME_CYC*6);
      rdy_rand = 1'b0;

      // Consumer stalls for several frame periods
      rdy = 1'b0;
      mode = 1;
      run(FRAME_CYC*3 + FRAME_CYC/2);
      rdy = 1'b1;
      run(FRAME_CYC);

      // Enable dropped mid-frame with a frame pending
      rdy = 1'b0;
      mode = 2;
      waited = 0;
      while (!valid_m && waited < 2*FRAME_CYC) begin
         run(1);
         waited++;
      end
      check("pending_frame_seen", valid_m, 1);
      run(30);
      enable_off();
      run(40);
      enable_on();
      run(20);
      rdy = 1'b1;
      run(FRAME_CYC*(ORDER+2));

      // Reset mid-frame while enabled
      mode = 4;
      run(FRAME_CYC/3);
      reset_pulse();
      run(FRAME_CYC*(ORDER+2));

      // Sparse random data
      mode = 0;
      dens = 30;
      run(FRAME_CYC*4);

      checks++;
      if (frames_seen < 20) begin
         failures++;
         $display("FAIL frames_seen: got %0d required at least 20", frames_seen);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
